sat_accumulator: RTL and testbench

SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

---
 rtl/sat_accumulator.sv | 113 +++++++++++
 tb/tb_sat_accumulator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sat_accumulator.sv
// Saturating signed add/subtract accumulator over a programmable number of terms.
// Operands stream in under valid/ready; the result is held until the consumer takes it.
module sat_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_sub,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_ovf,
    output logic                         busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                         state, state_next;
    logic signed [DATA_WIDTH-1:0]   acc_p0;
    logic                           ovf_p0;
    logic        [CNT_WIDTH-1:0]    cnt_p0;
    logic        [CNT_WIDTH-1:0]    len_p0;
    logic signed [DATA_WIDTH-1:0]   sum;
    logic                           sum_ovf;
    logic                           accept;
    logic                           last;

    // Ripple sum acc + (sub ? ~b : b) + sub; on signed overflow clamp toward the acc sign.
    // Returns {overflow, value}.
    function automatic logic [DATA_WIDTH:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b,
        input logic                         sub
    );
        logic [DATA_WIDTH-1:0] eff;
        logic [DATA_WIDTH-1:0] raw;
        logic                  ovf;
        eff = sub ? ~b : b;
        raw = a + eff + {{(DATA_WIDTH-1){1'b0}}, sub};
        ovf = (a[DATA_WIDTH-1] == eff[DATA_WIDTH-1]) && (raw[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
        if (ovf)
            raw = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                  : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return {ovf, raw};
    endfunction

    always_comb begin
        {sum_ovf, sum} = sat_add(acc_p0, in_data, in_sub);
    end

    assign accept = in_valid && (state == ACCUM);
    assign last   = accept && (cnt_p0 == (len_p0 - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start)
                    state_next = (len == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (last)
                    state_next = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: accumulator, sticky overflow, term counter and latched length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0 <= '0;
            ovf_p0 <= 1'b0;
            cnt_p0 <= '0;
            len_p0 <= '0;
        end else begin
            if (state == IDLE && start) begin
                acc_p0 <= '0;
                ovf_p0 <= 1'b0;
                cnt_p0 <= '0;
                len_p0 <= len;
            end else if (accept) begin
                acc_p0 <= sum;
                ovf_p0 <= ovf_p0 | sum_ovf;
                cnt_p0 <= cnt_p0 + 1'b1;
            end
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_data  = (state == DONE) ? acc_p0 : '0;
    assign out_ovf   = (state == DONE) ? ovf_p0 : 1'b0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator: hand-computed results, saturation, stalls, resets.
module tb_sat_accumulator;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [3:0]         len;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_sub;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               out_ovf;
    logic               busy;

    int checks = 0;
    int errors = 0;

    sat_accumulator #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = 4'd0;
    endtask

    task automatic feed(input logic signed [15:0] d, input logic sub);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = sub;
        tick();
        in_valid = 1'b0;
        in_data  = 16'sd0;
        in_sub   = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] d, input logic ovf);
        chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, "_data"},  out_data, d);
        chk({tag, "_ovf"},   {15'd0, out_ovf}, {15'd0, ovf});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = 16'sd0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready",  {15'd0, in_ready},  16'd0);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data",  out_data,           16'd0);
        chk("rst_out_ovf",   {15'd0, out_ovf},   16'd0);
        chk("rst_busy",      {15'd0, busy},      16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 100 - 50 + (-20) = 30
        do_start(4'd3);
        chk("t1_busy",  {15'd0, busy},     16'd1);
        chk("t1_ready", {15'd0, in_ready}, 16'd1);
        feed(16'sd100, 1'b0);
        feed(16'sd50, 1'b1);
        chk("t1_not_yet", {15'd0, out_valid}, 16'd0);
        feed(-16'sd20, 1'b0);
        chk("t1_ready_off", {15'd0, in_ready}, 16'd0);
        expect_result("t1", 16'd30, 1'b0);

        // 0x7000 + 0x2000 saturates positive
        do_start(4'd2);
        feed(16'sh7000, 1'b0);
        feed(16'sh2000, 1'b0);
        expect_result("t2", 16'h7FFF, 1'b1);

        // 0 - 0x8000 saturates positive via the ~B+1 path
        do_start(4'd2);
        feed(16'sh0000, 1'b0);
        feed(16'sh8000, 1'b1);
        expect_result("t3a", 16'h7FFF, 1'b1);

        // 0x8000 - 1 saturates negative
        do_start(4'd2);
        feed(16'sh8000, 1'b0);
        feed(16'sh0001, 1'b1);
        expect_result("t3b", 16'h8000, 1'b1);

        // len=4 with gaps: 10 + 20 - (-5) + 7 = 42, stray starts ignored
        do_start(4'd4);
        feed(16'sd10, 1'b0);
        tick();
        feed(16'sd20, 1'b0);
        start = 1'b1;
        len   = 4'd1;
        tick();
        start = 1'b0;
        len   = 4'd0;
        chk("t4_start_in_accum", {15'd0, in_ready}, 16'd1);
        feed(-16'sd5, 1'b1);
        tick();
        chk("t4_still_accum", {15'd0, out_valid}, 16'd0);
        feed(16'sd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 4'd0;
            chk("t4_stall_valid", {15'd0, out_valid}, 16'd1);
            chk("t4_stall_data",  out_data, 16'd42);
            tick();
        end
        start = 1'b1;
        expect_result("t4", 16'd42, 1'b0);
        start = 1'b0;
        tick();
        chk("t4_no_restart", {15'd0, busy}, 16'd0);

        // len=0 completes immediately with a cleared result
        do_start(4'd0);
        chk("t5_ready", {15'd0, in_ready}, 16'd0);
        expect_result("t5", 16'd0, 1'b0);

        // reset mid-accumulation
        do_start(4'd4);
        feed(16'sd3, 1'b0);
        feed(16'sd4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", {15'd0, in_ready},  16'd0);
        chk("t6_rst_busy",  {15'd0, busy},      16'd0);
        chk("t6_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("t6_rst_data",  out_data,           16'd0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'sd9;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_valid", {15'd0, out_valid}, 16'd0);
            chk("t6_no_ready", {15'd0, in_ready},  16'd0);
        end
        in_valid = 1'b0;
        do_start(4'd1);
        feed(16'sd5, 1'b0);
        expect_result("t6_new", 16'd5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
